// File: rtl/game_pkg.sv
// Shared definitions for the tilt-ball game flow controller:
// state codes, default coordinate width and rand_list field offsets.
package game_pkg;

  localparam int unsigned COORD_W = 10;

  typedef enum logic [3:0] {
    ST_PLAYING  = 4'h1,
    ST_FAIL     = 4'h2,
    ST_WIN      = 4'h3,
    ST_NEW      = 4'h4,
    ST_AGAIN    = 4'h5,
    ST_BALL_RST = 4'h6,
    ST_LOAD     = 4'h7,
    ST_NEXT     = 4'h8,
    ST_OVER     = 4'h9,
    ST_CLEAR    = 4'hA
  } state_e;

  // Each half is fh[0..n-1], wh, ball from LSB; X half low, Y half high.
  function automatic int unsigned rl_fh_lsb(int unsigned cw, int unsigned i);
    return i * cw;
  endfunction

  function automatic int unsigned rl_wh_lsb(int unsigned fh_num, int unsigned cw);
    return fh_num * cw;
  endfunction

  function automatic int unsigned rl_bl_lsb(int unsigned fh_num, int unsigned cw);
    return (fh_num + 1) * cw;
  endfunction

  function automatic int unsigned rl_y_lsb(int unsigned fh_num, int unsigned cw);
    return (fh_num + 2) * cw;
  endfunction

endpackage

// File: rtl/game_flow_ctrl_layout_latch.sv
// Layout registers for holes and ball start, captured from the
// random list in a single LOAD cycle.
module layout_latch #(
  parameter int unsigned FH_NUM  = 7,
  parameter int unsigned COORD_W = game_pkg::COORD_W,
  parameter int unsigned BL_X0   = 144,
  parameter int unsigned BL_Y0   = 74
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic                          load_i,
  input  logic [2*COORD_W*(FH_NUM+2)-1:0] rand_list_i,
  output logic [COORD_W*FH_NUM-1:0]     fh_x_o,
  output logic [COORD_W*FH_NUM-1:0]     fh_y_o,
  output logic [COORD_W-1:0]            wh_x_o,
  output logic [COORD_W-1:0]            wh_y_o,
  output logic [COORD_W-1:0]            bl_x_o,
  output logic [COORD_W-1:0]            bl_y_o
);
  import game_pkg::*;

  localparam int unsigned FH_W = COORD_W * FH_NUM;
  localparam int unsigned FH_O = rl_fh_lsb(COORD_W, 0);
  localparam int unsigned WH_O = rl_wh_lsb(FH_NUM, COORD_W);
  localparam int unsigned BL_O = rl_bl_lsb(FH_NUM, COORD_W);
  localparam int unsigned Y_O  = rl_y_lsb(FH_NUM, COORD_W);

  logic [FH_W-1:0]    fh_x_q, fh_y_q, fh_x_d, fh_y_d;
  logic [COORD_W-1:0] wh_x_q, wh_y_q, wh_x_d, wh_y_d;
  logic [COORD_W-1:0] bl_x_q, bl_y_q, bl_x_d, bl_y_d;

  assign fh_x_d = rand_list_i[FH_O +: FH_W];
  assign fh_y_d = rand_list_i[Y_O + FH_O +: FH_W];
  assign wh_x_d = rand_list_i[WH_O +: COORD_W];
  assign wh_y_d = rand_list_i[Y_O + WH_O +: COORD_W];
  assign bl_x_d = rand_list_i[BL_O +: COORD_W];
  assign bl_y_d = rand_list_i[Y_O + BL_O +: COORD_W];

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      fh_x_q <= '0;
      fh_y_q <= '0;
      wh_x_q <= '0;
      wh_y_q <= '0;
      bl_x_q <= COORD_W'(BL_X0);
      bl_y_q <= COORD_W'(BL_Y0);
    end else if (load_i) begin
      fh_x_q <= fh_x_d;
      fh_y_q <= fh_y_d;
      wh_x_q <= wh_x_d;
      wh_y_q <= wh_y_d;
      bl_x_q <= bl_x_d;
      bl_y_q <= bl_y_d;
    end
  end

  assign fh_x_o = fh_x_q;
  assign fh_y_o = fh_y_q;
  assign wh_x_o = wh_x_q;
  assign wh_y_o = wh_y_q;
  assign bl_x_o = bl_x_q;
  assign bl_y_o = bl_y_q;

endmodule

// File: rtl/game_flow_ctrl.sv
// Multi-level tilt-ball game flow: levels, lives, layout requests, outcome.
// Optional per-level frame timeout enabled by GAME_FLOW_TIMEOUT_EN.
module game_flow_ctrl #(
  parameter int unsigned FH_NUM         = 7,
  parameter int unsigned COORD_W        = game_pkg::COORD_W,
  parameter int unsigned NUM_LEVELS     = 4,
  parameter int unsigned MAX_LIVES      = 3,
  parameter int unsigned BL_X0          = 144,
`ifdef GAME_FLOW_TIMEOUT_EN
  parameter int unsigned TIMEOUT_FRAMES = 1800,
`endif
  parameter int unsigned BL_Y0          = 74
) (
  input  logic                            CLK,
  input  logic                            rst,
  input  logic                            i_new_game,
  input  logic                            i_again,
  input  logic                            i_accel_ready,
  input  logic                            i_rand_ready,
  input  logic [2*COORD_W*(FH_NUM+2)-1:0] i_rand_list,
  input  logic                            i_frame_tick,
  input  logic                            i_win,
  input  logic                            i_fail,
  input  logic [COORD_W-1:0]              i_roll_x,
  input  logic [COORD_W-1:0]              i_roll_y,
  input  logic [COORD_W-1:0]              i_fix_x,
  input  logic [COORD_W-1:0]              i_fix_y,
  output logic                            o_rand_req,
  output logic [COORD_W*FH_NUM-1:0]       o_fh_x,
  output logic [COORD_W*FH_NUM-1:0]       o_fh_y,
  output logic [COORD_W-1:0]              o_wh_x,
  output logic [COORD_W-1:0]              o_wh_y,
  output logic [COORD_W-1:0]              o_bl_init_x,
  output logic [COORD_W-1:0]              o_bl_init_y,
  output logic [COORD_W-1:0]              o_bl_x,
  output logic [COORD_W-1:0]              o_bl_y,
  output logic                            o_bl_pos_rst,
  output logic                            o_playing,
  output logic [3:0]                      o_level,
  output logic [3:0]                      o_lives,
  output logic [3:0]                      o_state,
  output logic                            o_game_over,
  output logic                            o_all_clear
`ifdef GAME_FLOW_TIMEOUT_EN
  ,
  output logic [15:0]                     o_time_left
`endif
);
  import game_pkg::*;

  state_e     state_q, state_d;
  logic [3:0] level_q, level_d;
  logic [3:0] lives_q, lives_d;
  logic       arm_q, arm_d;
  logic       req_q, req_d;
  logic       over_q, clear_q;
  logic       tmo;
  logic       load;

  logic [COORD_W-1:0] fix_x, fix_y;

  assign load = (state_q == ST_LOAD);

  layout_latch #(
    .FH_NUM  (FH_NUM),
    .COORD_W (COORD_W),
    .BL_X0   (BL_X0),
    .BL_Y0   (BL_Y0)
  ) u_layout (
    .clk_i       (CLK),
    .rst_i       (rst),
    .load_i      (load),
    .rand_list_i (i_rand_list),
    .fh_x_o      (o_fh_x),
    .fh_y_o      (o_fh_y),
    .wh_x_o      (o_wh_x),
    .wh_y_o      (o_wh_y),
    .bl_x_o      (o_bl_init_x),
    .bl_y_o      (o_bl_init_y)
  );

  always_comb begin
    state_d = state_q;
    level_d = level_q;
    lives_d = lives_q;
    arm_d   = arm_q;
    req_d   = 1'b0;
    if (i_new_game) begin
      state_d = ST_NEW;
      level_d = '0;
      lives_d = 4'(MAX_LIVES);
      arm_d   = 1'b0;
      req_d   = 1'b1;
    end else if (i_again &&
                 (state_q inside {ST_PLAYING, ST_FAIL, ST_WIN})) begin
      state_d = ST_AGAIN;
    end else begin
      case (state_q)
        // A stale ready from the previous list must drop before loading.
        ST_NEW: begin
          arm_d = arm_q | ~i_rand_ready;
          if (arm_q && i_rand_ready && i_accel_ready) begin
            state_d = ST_LOAD;
            arm_d   = 1'b0;
          end
        end
        ST_NEXT: begin
          arm_d = arm_q | ~i_rand_ready;
          if (arm_q && i_rand_ready) begin
            state_d = ST_LOAD;
            arm_d   = 1'b0;
          end
        end
        ST_LOAD:     state_d = ST_BALL_RST;
        ST_BALL_RST: state_d = ST_PLAYING;
        ST_AGAIN:    state_d = ST_PLAYING;
        ST_PLAYING: begin
          if (i_fail || tmo) begin
            state_d = ST_FAIL;
            lives_d = (lives_q == 4'd0) ? 4'd0 : lives_q - 4'd1;
          end else if (i_win) begin
            state_d = ST_WIN;
          end
        end
        ST_FAIL: begin
          if (lives_q == 4'd0) state_d = ST_OVER;
        end
        ST_WIN: begin
          if (level_q == 4'(NUM_LEVELS - 1)) begin
            state_d = ST_CLEAR;
          end else if (i_frame_tick) begin
            state_d = ST_NEXT;
            level_d = level_q + 4'd1;
            arm_d   = 1'b0;
            req_d   = 1'b1;
          end
        end
        ST_OVER:  state_d = ST_OVER;
        ST_CLEAR: state_d = ST_CLEAR;
        default:  state_d = ST_NEW;
      endcase
    end
  end

  always_ff @(posedge CLK or posedge rst) begin
    if (rst) begin
      state_q <= ST_NEW;
      level_q <= '0;
      lives_q <= 4'(MAX_LIVES);
      arm_q   <= 1'b0;
      req_q   <= 1'b0;
      over_q  <= 1'b0;
      clear_q <= 1'b0;
    end else begin
      state_q <= state_d;
      level_q <= level_d;
      lives_q <= lives_d;
      arm_q   <= arm_d;
      req_q   <= req_d;
      over_q  <= (state_d == ST_OVER);
      clear_q <= (state_d == ST_CLEAR);
    end
  end

`ifdef GAME_FLOW_TIMEOUT_EN
  logic [15:0]        cnt_q, cnt_d;
  logic               hit_q, hit_d;
  logic [COORD_W-1:0] tx_q, ty_q, tx_d, ty_d;

  assign tmo = (state_q == ST_PLAYING) && i_frame_tick &&
               (cnt_q == 16'(TIMEOUT_FRAMES - 1));

  always_comb begin
    cnt_d = cnt_q;
    hit_d = hit_q;
    tx_d  = tx_q;
    ty_d  = ty_q;
    if (state_q == ST_PLAYING && i_frame_tick) cnt_d = cnt_q + 16'd1;
    if (state_d == ST_PLAYING && state_q != ST_PLAYING) begin
      cnt_d = '0;
      hit_d = 1'b0;
    end
    // No real fall happened, so the mover's fix position is stale.
    if (tmo && state_d == ST_FAIL && !i_fail) begin
      hit_d = 1'b1;
      tx_d  = i_roll_x;
      ty_d  = i_roll_y;
    end
  end

  always_ff @(posedge CLK or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
      hit_q <= 1'b0;
      tx_q  <= '0;
      ty_q  <= '0;
    end else begin
      cnt_q <= cnt_d;
      hit_q <= hit_d;
      tx_q  <= tx_d;
      ty_q  <= ty_d;
    end
  end

  assign fix_x       = hit_q ? tx_q : i_fix_x;
  assign fix_y       = hit_q ? ty_q : i_fix_y;
  assign o_time_left = 16'(TIMEOUT_FRAMES) - cnt_q;
`else
  assign tmo   = 1'b0;
  assign fix_x = i_fix_x;
  assign fix_y = i_fix_y;
`endif

  always_comb begin
    o_bl_x = o_bl_init_x;
    o_bl_y = o_bl_init_y;
    case (state_q)
      ST_PLAYING: begin
        o_bl_x = i_roll_x;
        o_bl_y = i_roll_y;
      end
      ST_FAIL, ST_WIN, ST_OVER, ST_CLEAR: begin
        o_bl_x = fix_x;
        o_bl_y = fix_y;
      end
      default: begin
        o_bl_x = o_bl_init_x;
        o_bl_y = o_bl_init_y;
      end
    endcase
  end

  assign o_playing    = (state_q == ST_PLAYING);
  assign o_bl_pos_rst = (state_q == ST_BALL_RST) || (state_q == ST_AGAIN);
  assign o_rand_req   = req_q;
  assign o_level      = level_q;
  assign o_lives      = lives_q;
  assign o_state      = state_q;
  assign o_game_over  = over_q;
  assign o_all_clear  = clear_q;

endmodule

// File: tb/tb_game_flow_ctrl.sv
// Directed-sequence bench with random layouts and ball positions for
// game_flow_ctrl; expected values come from the game rules.
module tb_game_flow_ctrl;

  localparam int FH = 7;
  localparam int CW = 10;
  localparam int NL = 2;
  localparam int ML = 3;
  localparam int LW = 2 * CW * (FH + 2);
  localparam int HALF = CW * (FH + 2);

  localparam int S_PLAY = 1, S_FAIL = 2, S_WIN = 3, S_NEW = 4;
  localparam int S_AGAIN = 5, S_BRST = 6, S_LOAD = 7, S_NEXT = 8;
  localparam int S_OVER = 9, S_CLEAR = 10;

  logic CLK = 1'b0;
  logic rst = 1'b1;
  logic i_new_game = 1'b0, i_again = 1'b0;
  logic i_accel_ready = 1'b0, i_rand_ready = 1'b0;
  logic [LW-1:0] i_rand_list = '0;
  logic i_frame_tick = 1'b0, i_win = 1'b0, i_fail = 1'b0;
  logic [CW-1:0] i_roll_x = '0, i_roll_y = '0;
  logic [CW-1:0] i_fix_x = '0, i_fix_y = '0;

  logic o_rand_req;
  logic [CW*FH-1:0] o_fh_x, o_fh_y;
  logic [CW-1:0] o_wh_x, o_wh_y, o_bl_init_x, o_bl_init_y;
  logic [CW-1:0] o_bl_x, o_bl_y;
  logic o_bl_pos_rst, o_playing, o_game_over, o_all_clear;
  logic [3:0] o_level, o_lives, o_state;
`ifdef GAME_FLOW_TIMEOUT_EN
  logic [15:0] o_time_left;
`endif

  int checks = 0;
  int failures = 0;
  int exp_level, exp_lives;
  int fx[FH], fy[FH];
  int wx, wy, bx, by;

  game_flow_ctrl #(
    .FH_NUM(FH), .COORD_W(CW), .NUM_LEVELS(NL), .MAX_LIVES(ML),
`ifdef GAME_FLOW_TIMEOUT_EN
    .TIMEOUT_FRAMES(5),
`endif
    .BL_X0(144), .BL_Y0(74)
  ) dut (
    .CLK(CLK), .rst(rst),
    .i_new_game(i_new_game), .i_again(i_again),
    .i_accel_ready(i_accel_ready), .i_rand_ready(i_rand_ready),
    .i_rand_list(i_rand_list), .i_frame_tick(i_frame_tick),
    .i_win(i_win), .i_fail(i_fail),
    .i_roll_x(i_roll_x), .i_roll_y(i_roll_y),
    .i_fix_x(i_fix_x), .i_fix_y(i_fix_y),
    .o_rand_req(o_rand_req),
    .o_fh_x(o_fh_x), .o_fh_y(o_fh_y),
    .o_wh_x(o_wh_x), .o_wh_y(o_wh_y),
    .o_bl_init_x(o_bl_init_x), .o_bl_init_y(o_bl_init_y),
    .o_bl_x(o_bl_x), .o_bl_y(o_bl_y),
    .o_bl_pos_rst(o_bl_pos_rst), .o_playing(o_playing),
    .o_level(o_level), .o_lives(o_lives), .o_state(o_state),
    .o_game_over(o_game_over), .o_all_clear(o_all_clear)
`ifdef GAME_FLOW_TIMEOUT_EN
    , .o_time_left(o_time_left)
`endif
  );

  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [127:0] obs,
                     input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int dec_sat(input int l);
    return (l == 0) ? 0 : l - 1;
  endfunction

  function automatic logic [CW*FH-1:0] holes(input int a[FH]);
    logic [CW*FH-1:0] r;
    for (int i = 0; i < FH; i++) r[i*CW +: CW] = CW'(a[i]);
    return r;
  endfunction

  task automatic new_layout(input int bxv, input int byv);
    logic [LW-1:0] l;
    for (int i = 0; i < FH; i++) begin
      fx[i] = $urandom_range(0, 1023);
      fy[i] = $urandom_range(0, 1023);
    end
    wx = $urandom_range(0, 1023);
    wy = $urandom_range(0, 1023);
    bx = (bxv < 0) ? $urandom_range(0, 1023) : bxv;
    by = (byv < 0) ? $urandom_range(0, 1023) : byv;
    l = '0;
    l[0 +: CW*FH] = holes(fx);
    l[HALF +: CW*FH] = holes(fy);
    l[FH*CW +: CW] = CW'(wx);
    l[HALF + FH*CW +: CW] = CW'(wy);
    l[(FH+1)*CW +: CW] = CW'(bx);
    l[HALF + (FH+1)*CW +: CW] = CW'(by);
    i_rand_list = l;
  endtask

  task automatic do_load(input bit accel, input int bxv, input int byv);
    i_rand_ready = 1'b0;
    tick();
    new_layout(bxv, byv);
    i_rand_ready = 1'b1;
    i_accel_ready = accel;
    tick();
    chk("load_state", o_state, S_LOAD);
    tick();
    chk("brst_state", o_state, S_BRST);
    chk("brst_posrst", o_bl_pos_rst, 1);
    chk("init_xy", {o_bl_init_x, o_bl_init_y}, {CW'(bx), CW'(by)});
    chk("brst_bl_x", o_bl_x, bx);
    chk("fh_x", o_fh_x, holes(fx));
    chk("fh_y", o_fh_y, holes(fy));
    chk("wh_xy", {o_wh_x, o_wh_y}, {CW'(wx), CW'(wy)});
    tick();
    chk("play_state", o_state, S_PLAY);
    chk("play_posrst", o_bl_pos_rst, 0);
    chk("playing", o_playing, 1);
    i_rand_ready = 1'b0;
  endtask

  task automatic roll_some();
    int n;
    n = $urandom_range(1, 3);
    for (int k = 0; k < n; k++) begin
      i_roll_x = CW'($urandom);
      i_roll_y = CW'($urandom);
      #1;
      chk("roll_x", o_bl_x, i_roll_x);
      chk("roll_y", o_bl_y, i_roll_y);
      tick();
    end
  endtask

  task automatic pulse_new_game();
    i_new_game = 1'b1;
    tick();
    i_new_game = 1'b0;
    exp_level = 0;
    exp_lives = ML;
    chk("ng_state", o_state, S_NEW);
    chk("ng_level", o_level, exp_level);
    chk("ng_lives", o_lives, exp_lives);
    chk("ng_req", o_rand_req, 1);
  endtask

  initial begin
    exp_level = 0;
    exp_lives = ML;
    repeat (2) tick();
    rst = 1'b0;
    chk("rst_state", o_state, S_NEW);
    chk("rst_level", o_level, 0);
    chk("rst_lives", o_lives, ML);
    chk("rst_init", {o_bl_init_x, o_bl_init_y}, {CW'(144), CW'(74)});
    chk("rst_bl_x", o_bl_x, 144);
    chk("rst_holes", {o_fh_x, o_fh_y, o_wh_x, o_wh_y}, 0);
    chk("rst_flags", {o_rand_req, o_game_over, o_all_clear}, 0);

    do_load(1'b1, 100, 60);
    roll_some();

    for (int n = 0; n < 3; n++) begin
      i_fix_x = CW'($urandom);
      i_fix_y = CW'($urandom);
      i_fail = 1'b1;
      tick();
      i_fail = 1'b0;
      exp_lives = dec_sat(exp_lives);
      chk("fail_state", o_state, S_FAIL);
      chk("fail_lives", o_lives, exp_lives);
      chk("fail_bl", {o_bl_x, o_bl_y}, {i_fix_x, i_fix_y});
      tick();
      if (exp_lives > 0) begin
        chk("fail_hold", o_state, S_FAIL);
        i_again = 1'b1;
        tick();
        i_again = 1'b0;
        chk("again_state", o_state, S_AGAIN);
        chk("again_posrst", o_bl_pos_rst, 1);
        chk("again_lives", o_lives, exp_lives);
        tick();
        chk("again_play", o_state, S_PLAY);
        roll_some();
      end else begin
        chk("over_state", o_state, S_OVER);
        chk("over_flag", o_game_over, 1);
        i_again = 1'b1;
        tick();
        i_again = 1'b0;
        chk("over_again_ign", o_state, S_OVER);
      end
    end

    pulse_new_game();
    chk("ng_over_clr", o_game_over, 0);
    tick();
    chk("ng_req_pulse", o_rand_req, 0);
    do_load(1'b1, -1, -1);

    i_win = 1'b1;
    i_fail = 1'b1;
    tick();
    i_win = 1'b0;
    i_fail = 1'b0;
    exp_lives = dec_sat(exp_lives);
    chk("wf_state", o_state, S_FAIL);
    chk("wf_lives", o_lives, exp_lives);
    i_again = 1'b1;
    tick();
    i_again = 1'b0;
    tick();
    chk("wf_replay", o_state, S_PLAY);

    i_fix_x = CW'($urandom);
    i_fix_y = CW'($urandom);
    i_win = 1'b1;
    tick();
    i_win = 1'b0;
    chk("win0_state", o_state, S_WIN);
    chk("win0_bl", {o_bl_x, o_bl_y}, {i_fix_x, i_fix_y});
    tick();
    chk("win0_wait", o_state, S_WIN);
    i_frame_tick = 1'b1;
    tick();
    i_frame_tick = 1'b0;
    exp_level++;
    chk("next_state", o_state, S_NEXT);
    chk("next_level", o_level, exp_level);
    chk("next_req", o_rand_req, 1);
    chk("next_lives", o_lives, exp_lives);
    chk("next_bl", o_bl_x, bx);
    tick();
    chk("next_req_off", o_rand_req, 0);
    do_load(1'b0, -1, -1);

    i_win = 1'b1;
    tick();
    i_win = 1'b0;
    chk("win1_state", o_state, S_WIN);
    tick();
    chk("clear_state", o_state, S_CLEAR);
    chk("clear_flag", o_all_clear, 1);
    chk("clear_level", o_level, NL - 1);
    i_again = 1'b1;
    tick();
    i_again = 1'b0;
    repeat ($urandom_range(1, 4)) tick();
    chk("clear_hold", o_state, S_CLEAR);

    pulse_new_game();
    tick();
    do_load(1'b1, -1, -1);
    i_win = 1'b1;
    tick();
    i_win = 1'b0;
    i_frame_tick = 1'b1;
    tick();
    i_frame_tick = 1'b0;
    chk("nx2_state", o_state, S_NEXT);
    chk("nx2_level", o_level, 1);
    pulse_new_game();
    chk("nx2_clear_flag", o_all_clear, 0);
    i_rand_ready = 1'b1;
    i_accel_ready = 1'b1;
    repeat (3) tick();
    chk("nx2_no_load", o_state, S_NEW);
    i_rand_ready = 1'b0;
    tick();
    i_rand_ready = 1'b1;
    tick();
    chk("nx2_load", o_state, S_LOAD);
    repeat (2) tick();
    chk("nx2_play", o_state, S_PLAY);
    i_rand_ready = 1'b0;

`ifdef GAME_FLOW_TIMEOUT_EN
    chk("tmo_start", o_time_left, 5);
    for (int k = 1; k <= 5; k++) begin
      i_roll_x = CW'($urandom);
      i_roll_y = CW'($urandom);
      i_frame_tick = 1'b1;
      tick();
      i_frame_tick = 1'b0;
      if (k < 5) begin
        chk("tmo_run", o_state, S_PLAY);
        chk("tmo_left", o_time_left, 5 - k);
        tick();
      end
    end
    exp_lives = dec_sat(exp_lives);
    chk("tmo_state", o_state, S_FAIL);
    chk("tmo_lives", o_lives, exp_lives);
    chk("tmo_left0", o_time_left, 0);
    begin
      logic [CW-1:0] lx, ly;
      lx = i_roll_x;
      ly = i_roll_y;
      i_roll_x = ~lx;
      i_fix_x = lx + CW'(1);
      i_fix_y = ly + CW'(1);
      #1;
      chk("tmo_bl", {o_bl_x, o_bl_y}, {lx, ly});
    end
`endif

    pulse_new_game();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    i_rand_ready = 1'b1;
    i_accel_ready = 1'b1;
    repeat (2) tick();
    chk("rst_disarm", o_state, S_NEW);
    chk("rst_lives2", o_lives, ML);
    i_rand_ready = 1'b0;
    tick();
    i_rand_ready = 1'b1;
    tick();
    chk("rst_rearm", o_state, S_LOAD);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/game_flow_ctrl.md
Name: game_flow_ctrl

Overview:
- Parametrised game-control state machine for the tilt-ball game; successor to the single-round controller in top.
- Adds multiple levels, a lives counter, a per-level random layout request and a game-over/all-clear outcome.
- Sits between getRandPos, accelBallMove, dropInHoles and drawScreenCtrl; owns hole and ball-start registers and the displayed ball position mux.

Parameters:
- FH_NUM, 7, number of fail holes.
- COORD_W, 10, coordinate width in bits.
- NUM_LEVELS, 4, levels per game (1..15).
- MAX_LIVES, 3, lives at game start (1..15).
- BL_X0, 144, ball x reset value.
- BL_Y0, 74, ball y reset value.
- TIMEOUT_FRAMES, 1800, frames allowed per level (TIMEOUT_EN only).

Ports:
- CLK  in  1  system clock, 100 MHz.
- rst  in  1  asynchronous active-high reset.
- i_new_game  in  1  one-cycle pulse; start a fresh game.
- i_again  in  1  one-cycle pulse; retry current level.
- i_accel_ready  in  1  accelerometer data valid (level).
- i_rand_ready  in  1  random list valid (level).
- i_rand_list  in  2*COORD_W*(FH_NUM+2)  packed layout: X half low, Y half high; each half ordered fh[FH_NUM], wh, ball from LSB.
- i_frame_tick  in  1  one-cycle end-of-frame pulse.
- i_win, i_fail  in  1  ball fell in win/fail hole.
- i_roll_x, i_roll_y  in  COORD_W  rolling ball position.
- i_fix_x, i_fix_y  in  COORD_W  fall-latched ball position.
- o_rand_req  out  1  one-cycle request for a new layout.
- o_fh_x, o_fh_y  out  COORD_W*FH_NUM  fail hole positions.
- o_wh_x, o_wh_y  out  COORD_W  win hole position.
- o_bl_init_x, o_bl_init_y  out  COORD_W  ball start position.
- o_bl_x, o_bl_y  out  COORD_W  displayed ball position.
- o_bl_pos_rst  out  1  ball mover reset.
- o_playing  out  1  state==PLAYING.
- o_level  out  4  current level, 0-based.
- o_lives  out  4  remaining lives.
- o_state  out  4  state code, for LEDs.
- o_game_over, o_all_clear  out  1  terminal outcome flags.

Behaviour:
- States and codes: NEW 0x4, LOAD 0x7, BALL_RST 0x6, AGAIN 0x5, PLAYING 0x1, FAIL 0x2, WIN 0x3, NEXT 0x8, OVER 0x9, CLEAR 0xA.
- Reset values: state NEW; level 0; lives MAX_LIVES; hole registers all 0; o_bl_init = (BL_X0, BL_Y0); o_rand_req 0; flags 0.
- Priority: rst > i_new_game > i_again > normal transitions.
- i_new_game: any state -> NEW, level 0, lives MAX_LIVES, o_rand_req pulses 1 cycle.
- i_again: accepted only in PLAYING, FAIL or WIN -> AGAIN, lives unchanged. Ignored elsewhere.
- NEW/NEXT wait: an arm flag sets once i_rand_ready is seen low after the request.
  - NEW -> LOAD when arm && i_rand_ready && i_accel_ready.
  - NEXT -> LOAD when arm && i_rand_ready.
- LOAD: latch all positions from i_rand_list in one cycle -> BALL_RST.
- BALL_RST and AGAIN: o_bl_pos_rst=1 for exactly one cycle -> PLAYING.
- PLAYING:
  - i_fail -> FAIL, lives decremented; i_fail wins over a simultaneous i_win.
  - i_win -> WIN.
- FAIL, next cycle: lives==0 -> OVER (o_game_over=1); else stay until i_again.
- WIN, next cycle: level==NUM_LEVELS-1 -> CLEAR (o_all_clear=1); else advance on the first i_frame_tick -> NEXT, level+1, o_rand_req pulse.
- OVER and CLEAR hold until i_new_game or rst.
- Ball mux:
  - PLAYING: o_bl = roll.
  - FAIL, WIN, OVER, CLEAR: o_bl = fix.
  - Else: o_bl = bl_init.
- Lives saturate at 0; level never exceeds NUM_LEVELS-1.
- rst mid-wait drops the arm flag. Outputs are registered except the combinational o_bl mux, o_playing and o_bl_pos_rst, which decode state.

Optional Feature:
- Macro GAME_FLOW_TIMEOUT_EN.
- With it: a frame counter clears on entering PLAYING and increments on i_frame_tick while PLAYING. On reaching TIMEOUT_FRAMES, treat as i_fail: FAIL, lives-1, ball shown at i_roll position latched at that cycle. Output o_time_left (16 bits) = TIMEOUT_FRAMES - count.
- Without it: no counter, no o_time_left port, no timeout.

Decomposition:
- Shared package game_pkg: state code constants, COORD_W, the rand_list field-offset localparams (fh/wh/ball, X/Y halves).
- One natural sub-module: layout_latch, holding the LOAD-time unpacking registers for holes and ball start.

Test Plan:
- Reset, then rand_ready=1 and accel_ready=1 with list ball=(100,60) -> LOAD, BALL_RST, PLAYING in 3 cycles; o_bl_init=(100,60); o_bl_pos_rst high exactly 1 cycle.
- PLAYING with MAX_LIVES=3, assert i_fail three times with i_again between -> lives 2,1,0; after the third, state OVER and o_game_over=1; further i_again is ignored.
- Same-cycle i_win and i_fail in PLAYING -> FAIL, lives-1.
- NUM_LEVELS=2: win level 0 -> NEXT on the next frame tick, o_rand_req pulse, level=1; win again -> CLEAR, o_all_clear=1.
- i_new_game during NEXT while rand_ready is low -> NEW, level 0, lives 3; no LOAD until ready toggles low then high.
- GAME_FLOW_TIMEOUT_EN with TIMEOUT_FRAMES=5: 5 frame ticks in PLAYING -> FAIL, lives-1, o_time_left=0.
